// File: rtl/popcount_argmax.sv
// rtl/popcount_argmax.sv - sequential per-channel popcount arg-max/arg-min with valid/ready handshakes
module popcount_argmax #(
  parameter int  InCnt   = 4,
  parameter int  InWdt   = 8,
  parameter bit  TieHigh = 1'b0,
  localparam int IdxWdt  = (InCnt > 1) ? $clog2(InCnt) : 1,
  localparam int CntWdt  = $clog2(InWdt + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [InCnt*InWdt-1:0] data_i,
  input  logic                   mode_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [IdxWdt-1:0]      idx_o,
  output logic [CntWdt-1:0]      cnt_o,
  output logic                   all_eq_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [InCnt*InWdt-1:0]   data_q, data_d;
  logic                     mode_q, mode_d;
  logic [IdxWdt-1:0]        ch_q, ch_d;
  logic [IdxWdt-1:0]        best_idx_q, best_idx_d;
  logic [CntWdt-1:0]        best_cnt_q, best_cnt_d;
  logic [CntWdt-1:0]        first_cnt_q, first_cnt_d;
  logic                     eq_q, eq_d;
  logic                     out_valid_q, out_valid_d;
  logic [IdxWdt-1:0]        idx_q, idx_d;
  logic [CntWdt-1:0]        cnt_q, cnt_d;
  logic                     all_eq_q, all_eq_d;

  logic [InWdt-1:0]         chan;
  logic [CntWdt-1:0]        pc;
  logic                     last;
  logic                     take;

  // Constant-index mux keeps the channel select free of wide variable offsets.
  always_comb begin
    chan = '0;
    for (int k = 0; k < InCnt; k++) begin
      if (ch_q == IdxWdt'(k)) chan = data_q[k*InWdt +: InWdt];
    end
    pc = '0;
    for (int i = 0; i < InWdt; i++) pc = pc + CntWdt'(chan[i]);
    last = (ch_q == IdxWdt'(InCnt - 1));
    take = (mode_q ? (pc < best_cnt_q) : (pc > best_cnt_q)) ||
           (TieHigh && (pc == best_cnt_q));
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    mode_d      = mode_q;
    ch_d        = ch_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    first_cnt_d = first_cnt_q;
    eq_d        = eq_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    all_eq_d    = all_eq_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d  = data_i;
          mode_d  = mode_i;
          ch_d    = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (ch_q == '0) begin
          best_cnt_d  = pc;
          best_idx_d  = '0;
          first_cnt_d = pc;
          eq_d        = 1'b1;
        end else begin
          if (take) begin
            best_cnt_d = pc;
            best_idx_d = ch_q;
          end
          eq_d = eq_q && (pc == first_cnt_q);
        end
        // The last channel folds straight into the registered result.
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          idx_d       = best_idx_d;
          cnt_d       = best_cnt_d;
          all_eq_d    = eq_d;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mode_q      <= 1'b0;
      ch_q        <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      first_cnt_q <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      all_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      ch_q        <= ch_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      first_cnt_q <= first_cnt_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      all_eq_q    <= all_eq_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = out_valid_q;
  assign idx_o       = idx_q;
  assign cnt_o       = cnt_q;
  assign all_eq_o    = all_eq_q;

endmodule

// File: tb/tb_popcount_argmax.sv
// tb/tb_popcount_argmax.sv - scoreboard bench for popcount_argmax, TieHigh 0 and 1 side by side
module tb_popcount_argmax;

  typedef struct {
    logic [1:0] idx_lo;
    logic [1:0] idx_hi;
    logic [3:0] cnt;
    logic       eq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        mode;
  logic        out_ready;
  logic [31:0] data;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, eq0, eq1;
  logic [1:0]  idx0, idx1;
  logic [3:0]  cnt0, cnt1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  popcount_argmax #(.InCnt(4), .InWdt(8), .TieHigh(1'b0)) u_lo (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .data_i(data), .mode_i(mode), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .idx_o(idx0), .cnt_o(cnt0), .all_eq_o(eq0)
  );

  popcount_argmax #(.InCnt(4), .InWdt(8), .TieHigh(1'b1)) u_hi (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .data_i(data), .mode_i(mode), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .idx_o(idx1), .cnt_o(cnt1), .all_eq_o(eq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int il, input int ih, input int c, input int e);
    exp_t r;
    r.idx_lo = 2'(il);
    r.idx_hi = 2'(ih);
    r.cnt    = 4'(c);
    r.eq     = e[0];
    return r;
  endfunction

  // Reference: find the extreme count, then pick the first or last channel holding it.
  function automatic exp_t model(input logic [31:0] d, input logic m);
    int   c[4];
    int   best;
    exp_t r;
    for (int k = 0; k < 4; k++) c[k] = $countones(d[k*8 +: 8]);
    best = c[0];
    for (int k = 1; k < 4; k++)
      if (m ? (c[k] < best) : (c[k] > best)) best = c[k];
    r.idx_lo = 2'd0;
    r.idx_hi = 2'd0;
    for (int k = 3; k >= 0; k--) if (c[k] == best) r.idx_lo = 2'(k);
    for (int k = 0; k < 4; k++)  if (c[k] == best) r.idx_hi = 2'(k);
    r.cnt = 4'(best);
    r.eq  = (c[1] == c[0]) && (c[2] == c[0]) && (c[3] == c[0]);
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    logic [7:0]  pool [5] = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h3C};
    logic [31:0] d;
    for (int k = 0; k < 4; k++)
      d[k*8 +: 8] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 4)] : 8'($urandom);
    return d;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid0 && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got idx %0d with empty scoreboard", idx0);
        end else begin
          e = sb_q.pop_front();
          check("res_idx_lo", 32'(idx0), 32'(e.idx_lo));
          check("res_idx_hi", 32'(idx1), 32'(e.idx_hi));
          check("res_cnt_lo", 32'(cnt0), 32'(e.cnt));
          check("res_cnt_hi", 32'(cnt1), 32'(e.cnt));
          check("res_eq_lo", 32'(eq0), 32'(e.eq));
          check("res_eq_hi", 32'(eq1), 32'(e.eq));
          check("res_valid_hi", 32'(out_valid1), 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic m, input exp_t e, input bit push);
    int n = 0;
    while (!in_ready0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("issue_in_ready", 32'(in_ready0), 32'd1);
    in_valid = 1'b1;
    data     = d;
    mode     = m;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data     = $urandom;
    mode     = 1'($urandom);
  endtask

  task automatic wait_result(input exp_t e, input int delay);
    int n = 0;
    do begin
      data = $urandom;
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid0 && n <= 20);
    check("latency", 32'(n), 32'd4);
    for (int i = 0; i < delay; i++) begin
      in_valid = (i == 0);
      data     = $urandom;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid0), 32'd1);
      check("hold_idx", 32'(idx0), 32'(e.idx_lo));
      check("hold_cnt", 32'(cnt0), 32'(e.cnt));
      check("hold_in_ready", 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("rel_valid", 32'(out_valid0), 32'd0);
    check("rel_in_ready", 32'(in_ready0), 32'd1);
    check("rel_idx_kept", 32'(idx0), 32'(e.idx_lo));
  endtask

  task automatic run_batch(input logic [31:0] d, input logic m, input exp_t e, input int delay);
    issue(d, m, e, 1'b1);
    wait_result(e, delay);
  endtask

  initial begin : stim
    logic [31:0] d;
    logic        m;
    int          n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    data      = '0;
    #12;
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_idx", 32'(idx0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    check("rst_eq", 32'(eq0), 32'd0);
    check("rst_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_batch(32'h00FF0FAA, 1'b0, mk(2, 2, 8, 0), 0);
    run_batch(32'h00FF0FAA, 1'b1, mk(3, 3, 0, 0), 0);
    run_batch(32'h40FEFF55, 1'b0, mk(1, 1, 8, 0), 5);
    run_batch(32'h40FEFF55, 1'b1, mk(3, 3, 1, 0), 1);
    run_batch(32'h3C330FAA, 1'b0, mk(0, 3, 4, 1), 0);
    run_batch(32'h3C330FAA, 1'b1, mk(0, 3, 4, 1), 2);
    run_batch(32'h00FF01FF, 1'b0, mk(0, 2, 8, 0), 0);

    for (int i = 0; i < 40; i++) begin
      d = rand_data();
      m = 1'($urandom);
      run_batch(d, m, model(d, m), $urandom_range(0, 3));
    end

    issue(32'h00FF0FAA, 1'b0, mk(2, 2, 8, 0), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid0), 32'd0);
    check("midrst_idx", 32'(idx0), 32'd0);
    check("midrst_cnt", 32'(cnt0), 32'd0);
    check("midrst_eq", 32'(eq0), 32'd0);
    check("midrst_in_ready", 32'(in_ready0), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_in_ready", 32'(in_ready0), 32'd1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid0) n++;
    end
    check("postrst_no_valid", 32'(n), 32'd0);
    run_batch(32'h40FEFF55, 1'b0, mk(1, 1, 8, 0), 0);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
